// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the multi-pass shift sequencer: controller state
// encoding and the largest shift the shared stage can apply in one pass.
package shift_sequencer_pkg;

  // Controller states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Largest amount the shared stage can shift in a single clock.
  localparam int MAX_STEP = 3;

endpackage : shift_sequencer_pkg

// File: rtl/shift_sequencer_shl_stage.sv
// Purely combinational left-shift stage: shifts a WIDTH-bit word left by
// 0..3 bits, filling vacated LSBs with zeros. Shared by the sequencer.
module shl_stage #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       amt_i,
  output logic [WIDTH-1:0] data_o
);

  // Logical left shift; the zero fill comes from the shift operator itself.
  always_comb begin
    data_o = data_i << amt_i;
  end

endmodule : shl_stage

// File: rtl/shift_sequencer.sv
// Multi-pass controller around the shared 0..3-bit left-shift stage.
// Takes an operand and an arbitrary shift amount, runs the stage up to three
// bits per clock until the amount is consumed, then presents the result over
// a valid/ready handshake. Callers never need to know the stage limit.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic [AMT_W-1:0] IN_AMT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             BUSY
);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [AMT_W-1:0] rem_q;
  logic [AMT_W-1:0] rem_d;

  logic [1:0]       step;
  logic [AMT_W-1:0] stepWide;
  logic [AMT_W-1:0] remAfter;
  logic [WIDTH-1:0] stageOut;

  // Pick this pass's shift: the whole remainder if it fits, else the stage max.
  // Because step never exceeds rem_q, the subtraction below cannot underflow.
  always_comb begin
    step     = 2'd0;
    stepWide = '0;
    remAfter = '0;
    if (rem_q > AMT_W'(MAX_STEP)) begin
      step = 2'(MAX_STEP);
    end else begin
      step = rem_q[1:0];
    end
    stepWide = AMT_W'(step);
    remAfter = rem_q - stepWide;
  end

  shl_stage #(
    .WIDTH (WIDTH)
  ) u_shl_stage (
    .data_i (data_q),
    .amt_i  (step),
    .data_o (stageOut)
  );

  // State, operand and remaining-amount registers; reset abandons any operation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic: accept in IDLE, one stage pass per SHIFT cycle, and hold
  // the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          data_d = IN_DATA;
          rem_d  = IN_AMT;
          if (IN_AMT == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = stageOut;
        rem_d  = remAfter;
        if (remAfter == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        data_d  = '0;
        rem_d   = '0;
      end
    endcase
  end

  // Handshake outputs decoded from state; the result is gated so partial
  // pass values never leak onto OUT_DATA.
  always_comb begin
    IN_READY  = (state_q == IDLE);
    OUT_VALID = (state_q == DONE);
    BUSY      = (state_q == SHIFT) || (state_q == DONE);
    OUT_DATA  = OUT_VALID ? data_q : '0;
  end

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (WIDTH=8, AMT_W=4).
module tb_shift_sequencer;

  logic       CLK;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] IN_DATA;
  logic [3:0] IN_AMT;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] OUT_DATA;
  logic       BUSY;

  int passCount  = 0;
  int checkCount = 0;

  shift_sequencer #(
    .WIDTH (8),
    .AMT_W (4)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .IN_AMT    (IN_AMT),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .BUSY      (BUSY)
  );

  // Free-running 10 ns clock.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one request for a single edge, then drop IN_VALID.
  task automatic applyStimulus(input logic [7:0] data, input logic [3:0] amt);
    IN_VALID = 1'b1;
    IN_DATA  = data;
    IN_AMT   = amt;
    tick();
    IN_VALID = 1'b0;
  endtask

  // Count edges after accept until OUT_VALID rises; -1 if it never does.
  task automatic waitValid(output int cycles, output bit busyAll);
    cycles  = 0;
    busyAll = BUSY;
    while (!OUT_VALID && cycles < 40) begin
      tick();
      cycles++;
      busyAll = busyAll & BUSY;
    end
    if (!OUT_VALID) cycles = -1;
  endtask

  // Take the result and return to IDLE.
  task automatic drain();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    IN_VALID = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    checkCount++;
    if (IN_READY !== 1'b1) $display("[TB] FAIL reset_in_ready got=%b want=1", IN_READY);
    else passCount++;
    checkCount++;
    if (OUT_VALID !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b want=0", OUT_VALID);
    else passCount++;
    checkCount++;
    if (OUT_DATA !== 8'h00) $display("[TB] FAIL reset_out_data got=%h want=00", OUT_DATA);
    else passCount++;
    checkCount++;
    if (BUSY !== 1'b0) $display("[TB] FAIL reset_busy got=%b want=0", BUSY);
    else passCount++;
  endtask

  task automatic test_amount0();
    int cycles;
    bit busyAll;
    applyStimulus(8'b11000111, 4'd0);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 0) $display("[TB] FAIL amt0_latency got=%0d want=0", cycles);
    else passCount++;
    checkCount++;
    if (OUT_DATA !== 8'b11000111) $display("[TB] FAIL amt0_data got=%b want=11000111", OUT_DATA);
    else passCount++;
    drain();
    checkCount++;
    if (IN_READY !== 1'b1 || OUT_VALID !== 1'b0) $display("[TB] FAIL amt0_release in_ready=%b out_valid=%b want 1/0", IN_READY, OUT_VALID);
    else passCount++;
  endtask

  task automatic test_amount5();
    int cycles;
    bit busyAll;
    applyStimulus(8'b11000111, 4'd5);
    checkCount++;
    if (OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00 || IN_READY !== 1'b0) $display("[TB] FAIL amt5_gated valid=%b data=%h in_ready=%b want 0/00/0", OUT_VALID, OUT_DATA, IN_READY);
    else passCount++;
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 2) $display("[TB] FAIL amt5_latency got=%0d want=2", cycles);
    else passCount++;
    checkCount++;
    if (OUT_DATA !== 8'b11100000) $display("[TB] FAIL amt5_data got=%b want=11100000", OUT_DATA);
    else passCount++;
    drain();
  endtask

  task automatic test_large_amounts();
    int cycles;
    bit busyAll;
    applyStimulus(8'hFF, 4'd8);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 3) $display("[TB] FAIL amt8_latency got=%0d want=3", cycles);
    else passCount++;
    checkCount++;
    if (OUT_DATA !== 8'h00) $display("[TB] FAIL amt8_data got=%h want=00", OUT_DATA);
    else passCount++;
    checkCount++;
    if (busyAll !== 1'b1) $display("[TB] FAIL amt8_busy got=%b want=1", busyAll);
    else passCount++;
    drain();
    applyStimulus(8'hFF, 4'd15);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 5) $display("[TB] FAIL amt15_latency got=%0d want=5", cycles);
    else passCount++;
    checkCount++;
    if (OUT_DATA !== 8'h00) $display("[TB] FAIL amt15_data got=%h want=00", OUT_DATA);
    else passCount++;
    checkCount++;
    if (busyAll !== 1'b1) $display("[TB] FAIL amt15_busy got=%b want=1", busyAll);
    else passCount++;
    drain();
    applyStimulus(8'h81, 4'd2);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 1 || OUT_DATA !== 8'h04) $display("[TB] FAIL amt2_result cycles=%0d data=%h want 1/04", cycles, OUT_DATA);
    else passCount++;
    drain();
  endtask

  task automatic test_backpressure();
    int cycles;
    bit busyAll;
    OUT_READY = 1'b0;
    applyStimulus(8'b11000111, 4'd3);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 1 || OUT_DATA !== 8'b00111000) $display("[TB] FAIL bp_first cycles=%0d data=%b want 1/00111000", cycles, OUT_DATA);
    else passCount++;
    IN_VALID = 1'b1;
    IN_DATA  = 8'h0F;
    IN_AMT   = 4'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkCount++;
      if (OUT_DATA !== 8'b00111000 || OUT_VALID !== 1'b1) $display("[TB] FAIL bp_hold[%0d] data=%b valid=%b want 00111000/1", i, OUT_DATA, OUT_VALID);
      else passCount++;
      checkCount++;
      if (IN_READY !== 1'b0) $display("[TB] FAIL bp_in_ready[%0d] got=%b want=0", i, IN_READY);
      else passCount++;
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    checkCount++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0) $display("[TB] FAIL bp_no_same_edge_accept in_ready=%b busy=%b want 1/0", IN_READY, BUSY);
    else passCount++;
    tick();
    IN_VALID = 1'b0;
    checkCount++;
    if (BUSY !== 1'b1 || IN_READY !== 1'b0) $display("[TB] FAIL bp_next_accept busy=%b in_ready=%b want 1/0", BUSY, IN_READY);
    else passCount++;
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 1 || OUT_DATA !== 8'h3C) $display("[TB] FAIL bp_second cycles=%0d data=%h want 1/3c", cycles, OUT_DATA);
    else passCount++;
    drain();
  endtask

  task automatic test_reset_mid_shift();
    int cycles;
    bit busyAll;
    bit sawValid;
    applyStimulus(8'hFF, 4'd15);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checkCount++;
    if (IN_READY !== 1'b1 || BUSY !== 1'b0 || OUT_VALID !== 1'b0 || OUT_DATA !== 8'h00) $display("[TB] FAIL midrst_idle in_ready=%b busy=%b valid=%b data=%h want 1/0/0/00", IN_READY, BUSY, OUT_VALID, OUT_DATA);
    else passCount++;
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      sawValid = sawValid | OUT_VALID;
    end
    checkCount++;
    if (sawValid !== 1'b0) $display("[TB] FAIL midrst_no_valid got=%b want=0", sawValid);
    else passCount++;
    applyStimulus(8'h81, 4'd1);
    waitValid(cycles, busyAll);
    checkCount++;
    if (cycles !== 1 || OUT_DATA !== 8'h02) $display("[TB] FAIL midrst_fresh cycles=%0d data=%h want 1/02", cycles, OUT_DATA);
    else passCount++;
    drain();
  endtask

  // Run each scenario in order, then report.
  initial begin
    RST       = 1'b1;
    IN_VALID  = 1'b0;
    IN_DATA   = 8'h00;
    IN_AMT    = 4'd0;
    OUT_READY = 1'b0;
    test_reset();
    test_amount0();
    test_amount5();
    test_large_amounts();
    test_backpressure();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule : tb_shift_sequencer
